// File: rtl/mod997_pkg.sv
// -----------------------------------------------------------------------------
// mod997_pkg
// Shared constants and types for the mod-997 reconstruction block
// (X = Q*997 + R, rebuilt one 10-bit quotient digit per cycle).
//
// Contents:
//   W_X, W_Q, DIGIT, W_R, MODULUS, N_DIGITS, IDX_W, W_P  - sizing constants
//   state_t                                              - control FSM states
// -----------------------------------------------------------------------------
package mod997_pkg;

  localparam int W_X      = 200;          // reconstructed X width
  localparam int W_Q      = 191;          // quotient width
  localparam int DIGIT    = 10;           // quotient bits consumed per cycle
  localparam int W_R      = 10;           // residue width
  localparam int MODULUS  = 997;
  localparam int N_DIGITS = W_X / DIGIT;  // 20 digits cover the padded Q
  localparam int IDX_W    = 5;            // holds 0..N_DIGITS inclusive
  localparam int W_P      = 2 * DIGIT;    // MAC result: low digit + carry

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/mod997_digit_mac.sv
// -----------------------------------------------------------------------------
// mod997_digit_mac
// Combinational digit multiply-accumulate: p = d*997 + c.
// The constant multiply is built from shifts: 997 = 1024 - 32 + 4 + 1.
// All terms are evaluated modulo 2^20; the true result is at most
// 1023*997 + 1023 = 1020954 < 2^20, so the wrap never loses information.
//
// Ports:
//   d  in  10  quotient digit
//   c  in  10  incoming carry (or residue on the first digit)
//   p  out 20  d*997 + c; p[9:0] is the result digit, p[19:10] the next carry
// -----------------------------------------------------------------------------
module mod997_digit_mac
  import mod997_pkg::*;
(
  input  logic [DIGIT-1:0] d,
  input  logic [DIGIT-1:0] c,
  output logic [W_P-1:0]   p
);

  logic [W_P-1:0] d_ext;
  logic [W_P-1:0] c_ext;

  always_comb begin
    d_ext = W_P'(d);
    c_ext = W_P'(c);
    p     = (d_ext << 10) - (d_ext << 5) + (d_ext << 2) + d_ext + c_ext;
  end

endmodule

// File: rtl/x_200_unmod_997.sv
// -----------------------------------------------------------------------------
// x_200_unmod_997
// Digit-serial reconstruction X = Q*997 + R (inverse of the 200-bit mod-997
// reducer). Q is consumed least-significant digit first, 10 bits per cycle,
// through a single shift-add MAC. The working register doubles as the Q shift
// register and the partial-X accumulator: each cycle the low Q digit is shifted
// out and the new X digit is shifted in at the top, so after 20 steps it holds X.
// A final commit cycle copies it into x_out, giving 21 clocks accept->out_valid.
//
// Optional feature (macro RESIDUE_CHECK_EN):
//   defined   - err flags r_in >= 997 captured at accept, cleared on next accept
//   undefined - err is tied 0 and no comparator is built
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    Q/R operands valid
//   in_ready   out  1    block can accept operands (IDLE only)
//   q_in       in   191  quotient Q
//   r_in       in   10   residue R (legal 0..996)
//   out_valid  out  1    result valid, held until out_ready
//   out_ready  in   1    consumer accepts result
//   x_out      out  200  low 200 bits of Q*997 + R
//   ovf        out  1    full Q*997 + R >= 2^200
//   err        out  1    residue-range error (RESIDUE_CHECK_EN only)
// -----------------------------------------------------------------------------
module x_200_unmod_997
  import mod997_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W_Q-1:0] q_in,
  input  logic [W_R-1:0] r_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W_X-1:0] x_out,
  output logic           ovf,
  output logic           err
);

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     idx;
  logic [DIGIT-1:0]     carry;
  logic [W_X-1:0]       work;
  logic [W_P-1:0]       p;
  logic                 load;
  logic                 step;
  logic                 commit;

  mod997_digit_mac u_mac (
    .d (work[DIGIT-1:0]),
    .c (carry),
    .p (p)
  );

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // idx reaching N_DIGITS means all 20 digits are folded in; this
        // extra cycle publishes the result.
        if (idx == IDX_W'(N_DIGITS)) begin
          commit    = 1'b1;
          state_nxt = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: the 200-bit registers are reset too: x_out's reset value is visible
  // at the port, and clearing work/carry keeps an aborted op from leaking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= '0;
      carry <= '0;
      idx   <= '0;
      x_out <= '0;
      ovf   <= 1'b0;
    end else if (load) begin
      work  <= {{(W_X - W_Q){1'b0}}, q_in};
      carry <= r_in;
      idx   <= '0;
    end else if (step) begin
      // Q digit leaves at the bottom, X digit enters at the top.
      work  <= {p[DIGIT-1:0], work[W_X-1:DIGIT]};
      carry <= p[W_P-1:DIGIT];
      idx   <= idx + IDX_W'(1);
    end else if (commit) begin
      x_out <= work;
      // Final carry is X bits 200..209; anything there is lost from x_out.
      ovf   <= (carry != '0);
      idx   <= '0;
    end
  end

`ifdef RESIDUE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    err <= 1'b0;
    else if (load) err <= (r_in >= W_R'(MODULUS));
  end
`else
  assign err = 1'b0;
`endif

endmodule
